// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: turns jump, load-use and multi-cycle EX
// requests into per-stage hold codes (00 pass, 01 flush, 10 hold).
module pipe_hold_ctrl #(
  parameter int FLUSH_CYC = 2,
  parameter int MAX_STALL = 64,
  parameter int CW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump_i,
  input  logic          load_use_i,
  input  logic          ex_busy_i,
  output logic [1:0]    hold_pc_o,
  output logic [1:0]    hold_if_id_o,
  output logic [1:0]    hold_id_ex_o,
  output logic          pc_jump_o,
  output logic [CW-1:0] stall_cnt_o,
  output logic          stall_timeout_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  localparam logic [1:0] H_PASS  = 2'b00;
  localparam logic [1:0] H_FLUSH = 2'b01;
  localparam logic [1:0] H_HOLD  = 2'b10;

  localparam logic [3:0]  FCNT_LOAD = 4'(FLUSH_CYC - 1);
  localparam logic [15:0] BCNT_SAT  = 16'hFFFF;
  localparam logic [15:0] STALL_LIM = 16'(MAX_STALL);

  logic [1:0]    r_state;
  logic [3:0]    r_fcnt;
  logic [15:0]   r_bcnt;
  logic [CW-1:0] r_stall_cnt;
  logic          r_timeout;

  logic [1:0]    w_state_next;
  logic [3:0]    w_fcnt_next;
  logic [15:0]   w_bcnt_next;
  logic [1:0]    w_hold_pc;
  logic [1:0]    w_hold_if_id;
  logic [1:0]    w_hold_id_ex;
  logic          w_pc_jump;
  logic          w_jump_take;

  always_comb begin
    w_state_next = r_state;
    w_fcnt_next  = r_fcnt;
    w_bcnt_next  = r_bcnt;
    w_hold_pc    = H_PASS;
    w_hold_if_id = H_PASS;
    w_hold_id_ex = H_PASS;
    w_pc_jump    = 1'b0;
    w_jump_take  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (jump_i) begin
          w_jump_take = 1'b1;
        end else if (ex_busy_i) begin
          w_hold_pc    = H_HOLD;
          w_hold_if_id = H_HOLD;
          w_hold_id_ex = H_HOLD;
          w_bcnt_next  = 16'd1;
          w_state_next = S_BUSY;
        end else if (load_use_i) begin
          w_hold_pc    = H_HOLD;
          w_hold_if_id = H_HOLD;
          w_hold_id_ex = H_FLUSH;
        end
      end
      // Hazard requests here belong to instructions already being squashed.
      S_FLUSH: begin
        w_hold_if_id = H_FLUSH;
        w_hold_id_ex = H_FLUSH;
        if (jump_i) begin
          w_jump_take = 1'b1;
        end else begin
          w_fcnt_next = r_fcnt - 4'd1;
          if (r_fcnt == 4'd1) begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_BUSY: begin
        if (ex_busy_i) begin
          w_hold_pc    = H_HOLD;
          w_hold_if_id = H_HOLD;
          w_hold_id_ex = H_HOLD;
          w_bcnt_next  = (r_bcnt == BCNT_SAT) ? r_bcnt : r_bcnt + 16'd1;
        end else begin
          w_bcnt_next  = 16'd0;
          w_state_next = S_IDLE;
          w_jump_take  = jump_i;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Shared redirect path: the newest jump always restarts the flush window.
    if (w_jump_take) begin
      w_pc_jump    = 1'b1;
      w_hold_pc    = H_PASS;
      w_hold_if_id = H_FLUSH;
      w_hold_id_ex = H_FLUSH;
      if (FLUSH_CYC > 1) begin
        w_state_next = S_FLUSH;
        w_fcnt_next  = FCNT_LOAD;
      end else begin
        w_state_next = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_fcnt      <= 4'd0;
      r_bcnt      <= 16'd0;
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_fcnt  <= w_fcnt_next;
      r_bcnt  <= w_bcnt_next;
      if (w_hold_pc == H_HOLD) begin
        r_stall_cnt <= r_stall_cnt + CW'(1);
      end
      if (w_bcnt_next >= STALL_LIM) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Reset forces flush codes directly so they appear without waiting for a clock.
  assign hold_pc_o       = rst ? w_hold_pc    : H_FLUSH;
  assign hold_if_id_o    = rst ? w_hold_if_id : H_FLUSH;
  assign hold_id_ex_o    = rst ? w_hold_id_ex : H_FLUSH;
  assign pc_jump_o       = rst & w_pc_jump;
  assign stall_cnt_o     = r_stall_cnt;
  assign stall_timeout_o = r_timeout;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Scoreboard bench for pipe_hold_ctrl: a driver pushes model predictions,
// a negedge monitor pops and compares them against the live outputs.
module tb_pipe_hold_ctrl;

  localparam int FC = 2;
  localparam int MS = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_i = 1'b0;
  logic        load_use_i = 1'b0;
  logic        ex_busy_i = 1'b0;
  logic [1:0]  hold_pc_o;
  logic [1:0]  hold_if_id_o;
  logic [1:0]  hold_id_ex_o;
  logic        pc_jump_o;
  logic [31:0] stall_cnt_o;
  logic        stall_timeout_o;

  pipe_hold_ctrl #(.FLUSH_CYC(FC), .MAX_STALL(MS), .CW(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .jump_i          (jump_i),
    .load_use_i      (load_use_i),
    .ex_busy_i       (ex_busy_i),
    .hold_pc_o       (hold_pc_o),
    .hold_if_id_o    (hold_if_id_o),
    .hold_id_ex_o    (hold_id_ex_o),
    .pc_jump_o       (pc_jump_o),
    .stall_cnt_o     (stall_cnt_o),
    .stall_timeout_o (stall_timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  pc;
    logic [1:0]  ifid;
    logic [1:0]  idex;
    logic        pj;
    logic [31:0] sc;
    logic        to;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   txn = 0;

  // Reference model: remaining flush cycles, current busy run length, counters.
  int          m_flush_left = 0;
  int          m_busy_len = 0;
  logic [31:0] m_stalls = 0;
  logic        m_timeout = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic predict(input bit r, input bit j, input bit lu, input bit eb, output exp_t e);
    bit jump_now;
    e.pc = 2'b00; e.ifid = 2'b00; e.idex = 2'b00; e.pj = 1'b0;
    if (!r) begin
      m_flush_left = 0; m_busy_len = 0; m_stalls = 0; m_timeout = 1'b0;
      e.pc = 2'b01; e.ifid = 2'b01; e.idex = 2'b01;
      e.sc = 0; e.to = 1'b0;
      return;
    end
    e.sc = m_stalls;
    e.to = m_timeout;
    jump_now = 1'b0;
    if (m_busy_len > 0) begin
      if (eb) begin
        e.pc = 2'b10; e.ifid = 2'b10; e.idex = 2'b10;
        if (m_busy_len < 65535) m_busy_len++;
        if (m_busy_len >= MS) m_timeout = 1'b1;
      end else begin
        m_busy_len = 0;
        jump_now = j;
      end
    end else if (m_flush_left > 0) begin
      e.ifid = 2'b01; e.idex = 2'b01;
      if (j) jump_now = 1'b1;
      else m_flush_left--;
    end else if (j) begin
      jump_now = 1'b1;
    end else if (eb) begin
      e.pc = 2'b10; e.ifid = 2'b10; e.idex = 2'b10;
      m_busy_len = 1;
    end else if (lu) begin
      e.pc = 2'b10; e.ifid = 2'b10; e.idex = 2'b01;
    end
    if (jump_now) begin
      e.pc = 2'b00; e.ifid = 2'b01; e.idex = 2'b01; e.pj = 1'b1;
      m_flush_left = FC - 1;
    end
    if (e.pc == 2'b10) m_stalls = m_stalls + 1;
  endtask

  task automatic drive(input bit r, input bit j, input bit lu, input bit eb);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; jump_i = j; load_use_i = lu; ex_busy_i = eb;
    predict(r, j, lu, eb, e);
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        txn++;
        $display("txn %0d rst=%0b j=%0b lu=%0b eb=%0b -> pc=%b ifid=%b idex=%b pj=%0b sc=%0d to=%0b",
                 txn, rst, jump_i, load_use_i, ex_busy_i, hold_pc_o, hold_if_id_o,
                 hold_id_ex_o, pc_jump_o, stall_cnt_o, stall_timeout_o);
        chk("hold_pc", 32'(hold_pc_o), 32'(e.pc));
        chk("hold_if_id", 32'(hold_if_id_o), 32'(e.ifid));
        chk("hold_id_ex", 32'(hold_id_ex_o), 32'(e.idex));
        chk("pc_jump", 32'(pc_jump_o), 32'(e.pj));
        chk("stall_cnt", stall_cnt_o, e.sc);
        chk("stall_timeout", 32'(stall_timeout_o), 32'(e.to));
      end
    end
  end

  initial begin : driver
    int busy_rem;
    bit r, j, lu, eb;
    // Reset, then quiet pipeline.
    repeat (3) drive(0, 0, 0, 0);
    repeat (2) drive(1, 0, 0, 0);
    // Single jump, then back-to-back jumps extending the flush.
    drive(1, 1, 0, 0);
    repeat (3) drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    repeat (3) drive(1, 0, 0, 0);
    // One load-use bubble, then a sustained one.
    drive(1, 0, 1, 0);
    drive(1, 0, 0, 0);
    repeat (3) drive(1, 0, 1, 0);
    drive(1, 0, 0, 0);
    // Divider run below the watchdog limit, then one past it.
    repeat (33) drive(1, 0, 0, 1);
    drive(1, 0, 0, 0);
    repeat (70) drive(1, 0, 0, 1);
    repeat (3) drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    // Priority: everything at once in IDLE.
    drive(1, 1, 1, 1);
    drive(1, 0, 1, 1);
    repeat (2) drive(1, 0, 0, 0);
    // Jump in the cycle busy drops, and jump ignored while busy.
    repeat (4) drive(1, 0, 0, 1);
    drive(1, 1, 0, 1);
    drive(1, 1, 0, 0);
    repeat (3) drive(1, 0, 0, 0);
    // Asynchronous reset mid-BUSY.
    repeat (5) drive(1, 0, 0, 1);
    drive(0, 0, 0, 1);
    #1;
    chk("async_rst_pc", 32'(hold_pc_o), 32'(2'b01));
    chk("async_rst_id_ex", 32'(hold_id_ex_o), 32'(2'b01));
    drive(1, 0, 0, 0);
    // Randomized traffic.
    busy_rem = 0;
    for (int n = 0; n < 2000; n++) begin
      r  = ($urandom_range(0, 299) != 0);
      j  = ($urandom_range(0, 9) == 0);
      lu = ($urandom_range(0, 4) == 0);
      if (busy_rem > 0) begin
        eb = 1'b1;
        busy_rem--;
      end else begin
        eb = ($urandom_range(0, 7) == 0);
        if (eb) busy_rem = $urandom_range(0, 80);
      end
      drive(r, j, lu, eb);
    end
    repeat (2) drive(1, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hold_ctrl.md
Name: pipe_hold_ctrl

Overview:
Pipeline hold/flush controller that drives the 2-bit hold codes consumed by every pipeline register: 00 = pass, 01 = flush (load NOP/set value), 10 = hold.
It arbitrates jump redirects, load-use hazards and multi-cycle EX operations, for example the divider, into per-stage codes for PC, IF/ID and ID/EX.
It also keeps a stall-cycle counter and a sticky stall-watchdog flag.
It sits beside the core pipeline, taking requests from decode and execute.

Parameters:
FLUSH_CYC, 2, cycles IF/ID and ID/EX are flushed after a jump (legal 1..15)
MAX_STALL, 64, consecutive ex_busy cycles before the watchdog flag sets (legal 2..65535)
CW, 32, width of the stall-cycle counter

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-low reset
jump_i  input  1  jump/branch taken, from EX; one-cycle pulse
load_use_i  input  1  load-use hazard detected in ID
ex_busy_i  input  1  multi-cycle unit in EX not finished
hold_pc_o  output  2  hold code for PC register
hold_if_id_o  output  2  hold code for IF/ID register
hold_id_ex_o  output  2  hold code for ID/EX register
pc_jump_o  output  1  PC loads the jump target this edge
stall_cnt_o  output  CW  cycles in which hold_pc_o == 10, wraps modulo 2^CW
stall_timeout_o  output  1  sticky watchdog flag

Behaviour:
- Single clock. Reset is asynchronous and active-low on rst.
- While rst = 0: state = IDLE, all counters = 0, stall_timeout_o = 0, pc_jump_o = 0, and all three hold codes = 01.
- Hold codes and pc_jump_o are combinational from the current state and the current inputs, so they take effect at the next posedge. All state is registered.
- States: IDLE, FLUSH, BUSY. Internal counters: fcnt (4 bit) and bcnt (16 bit, saturating).
- IDLE, priority jump_i > ex_busy_i > load_use_i:
  - jump_i: pc = 00, if_id = 01, id_ex = 01, pc_jump_o = 1. If FLUSH_CYC > 1, go to FLUSH with fcnt = FLUSH_CYC-1; otherwise stay in IDLE.
  - ex_busy_i: all codes = 10. Go to BUSY with bcnt = 1.
  - load_use_i: pc = 10, if_id = 10, id_ex = 01 (one bubble). Stay in IDLE. If load_use_i stays high, the bubble repeats every cycle.
  - None asserted: all codes = 00.
- FLUSH:
  - pc = 00, if_id = 01, id_ex = 01.
  - load_use_i and ex_busy_i are ignored, because they come from instructions being flushed.
  - fcnt decrements each cycle. When fcnt == 1, go to IDLE.
  - jump_i in FLUSH: pc_jump_o = 1 and fcnt reloads to FLUSH_CYC-1 (the newest jump wins).
- BUSY:
  - While ex_busy_i = 1: all codes = 10, bcnt increments and saturates.
  - When bcnt reaches MAX_STALL, stall_timeout_o is set. It stays set until reset.
  - When ex_busy_i = 0: all codes = 00, bcnt is cleared, go to IDLE. That cycle is the EX writeback cycle.
  - jump_i while ex_busy_i = 1 is a protocol violation: it is ignored and pc_jump_o = 0.
  - jump_i in the cycle ex_busy_i falls is handled exactly as in IDLE.
- stall_cnt_o increments on every posedge where hold_pc_o == 10 and rst = 1. It wraps to 0 after all-ones.
- Reset asserted mid-FLUSH or mid-BUSY aborts immediately. There is no carry-over of fcnt, bcnt or stall_timeout_o.
- Hold codes 11 are never produced.

Test Plan:
- Reset: hold rst low for 3 cycles -> all hold codes 01, stall_cnt_o = 0, stall_timeout_o = 0. Release rst -> codes 00 on the next cycle with no inputs asserted.
- Jump with FLUSH_CYC = 2: jump_i pulse at cycle 5 -> pc_jump_o = 1 and if_id/id_ex = 01 in cycles 5 and 6, pc = 00 throughout, codes 00 at cycle 7. A second jump_i at cycle 6 -> flush extends through cycle 7.
- Load-use: load_use_i high for 1 cycle -> pc = 10, if_id = 10, id_ex = 01 for exactly that cycle; stall_cnt_o increases by 1.
- Divider busy: ex_busy_i high for 33 cycles -> all codes 10 for 33 cycles, then 00; stall_cnt_o increases by 33; stall_timeout_o stays 0.
- Watchdog with MAX_STALL = 64: ex_busy_i high for 70 cycles -> stall_timeout_o rises when bcnt reaches 64 and stays 1 after ex_busy_i drops, until rst is pulsed low.
- Priority: jump_i, ex_busy_i and load_use_i all high in IDLE -> jump flush codes and pc_jump_o = 1, state FLUSH, no stall counted. Pulse rst low mid-BUSY -> all codes 01 immediately (asynchronous).
